// File: rtl/conv1_event_scheduler.sv
// rtl/conv1_event_scheduler.sv - layer-1 convolution event scheduler (AER event scatter over the kernel)
//
// Ports:
//   work_clk, rst_n        clock, asynchronous active-low reset
//   ev_valid/ev_ready      input spike event handshake, ev_m/ev_n = unpadded pixel
//   step_end               pulse: timestep input finished
//   step_done              pulse: all events of the step written back
//   ev_drop                pulse: out-of-range event discarded
//   busy                   scheduler not idle
//   ev_count               events scanned in the current step
//   operating_flag         read-modify-write request valid to the core
//   Vmem_ram_address       padded Vmem map address of the target neuron
//   Weight_rom_address     kernel weight address (kernel is applied flipped)
//   Location_M/Location_N  padded-map row/column of the target neuron
//
// Optional feature macro: CONV1_SCAN_PADSKIP_EN
//   When defined, kernel positions landing on pad neurons are stepped but not issued.
module conv1_event_scheduler #(
    parameter int KSIZE     = 5,
    parameter int PAD       = 2,
    parameter int IMG_H     = 28,
    parameter int IMG_W     = 28,
    parameter int DRAIN_CYC = 3
) (
    input  logic        work_clk,
    input  logic        rst_n,
    input  logic        ev_valid,
    output logic        ev_ready,
    input  logic [7:0]  ev_m,
    input  logic [7:0]  ev_n,
    input  logic        step_end,
    output logic        step_done,
    output logic        ev_drop,
    output logic        busy,
    output logic [15:0] ev_count,
    output logic        operating_flag,
    output logic [15:0] Vmem_ram_address,
    output logic [4:0]  Weight_rom_address,
    output logic [7:0]  Location_M,
    output logic [7:0]  Location_N
);

    localparam int IW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [IW-1:0] K_LAST = IW'(KSIZE - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DRAIN_CYC - 1);
    localparam logic [15:0]   ROW_W  = 16'(IMG_W + 2 * PAD);
    localparam logic [7:0]    IMG_H8 = 8'(IMG_H);
    localparam logic [7:0]    IMG_W8 = 8'(IMG_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] i_q;
    logic [IW-1:0] j_q;
    logic [DW-1:0] drain_cnt;
    logic [7:0]    m_q;
    logic [7:0]    n_q;
    logic          pending;

    logic          ev_in_range;
    logic [IW-1:0] nxt_i;
    logic [IW-1:0] nxt_j;
    logic [7:0]    src_m;
    logic [7:0]    src_n;
    logic [7:0]    loc_m_nxt;
    logic [7:0]    loc_n_nxt;
    logic [15:0]   addr_nxt;
    logic [4:0]    wadr_nxt;
    logic          flag_nxt;

    // Ready and busy are pure decodes of registered state, so no input-to-output path.
    assign ev_ready = (state == IDLE) && !pending;
    assign busy     = (state != IDLE);

    assign ev_in_range = (ev_m < IMG_H8) && (ev_n < IMG_W8);

    // Outputs are registered one position ahead: the accept edge already loads
    // position (0,0) and every SCAN edge loads the following position, so the
    // core sees position k exactly k cycles after the accept.
    always_comb begin
        src_m = m_q;
        src_n = n_q;
        nxt_i = i_q;
        nxt_j = j_q;
        if (state == IDLE) begin
            src_m = ev_m;
            src_n = ev_n;
            nxt_i = '0;
            nxt_j = '0;
        end else if (j_q == K_LAST) begin
            nxt_i = i_q + 1'b1;
            nxt_j = '0;
        end else begin
            nxt_j = j_q + 1'b1;
        end

        // The padded map shifts by PAD, so the top-left kernel tap lands on row m itself.
        loc_m_nxt = src_m + {{(8 - IW){1'b0}}, nxt_i};
        loc_n_nxt = src_n + {{(8 - IW){1'b0}}, nxt_j};
        addr_nxt  = {8'd0, loc_m_nxt} * ROW_W + {8'd0, loc_n_nxt};
        // Scattering is a correlation seen from the target neuron, hence the flipped kernel index.
        wadr_nxt  = 5'((KSIZE - 1 - int'(nxt_i)) * KSIZE + (KSIZE - 1 - int'(nxt_j)));

`ifdef CONV1_SCAN_PADSKIP_EN
        flag_nxt = (loc_m_nxt >= 8'(PAD)) && (loc_m_nxt < 8'(PAD + IMG_H)) &&
                   (loc_n_nxt >= 8'(PAD)) && (loc_n_nxt < 8'(PAD + IMG_W));
`else
        flag_nxt = 1'b1;
`endif
    end

    always_ff @(posedge work_clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            i_q                <= '0;
            j_q                <= '0;
            drain_cnt          <= '0;
            m_q                <= '0;
            n_q                <= '0;
            pending            <= 1'b0;
            step_done          <= 1'b0;
            ev_drop            <= 1'b0;
            ev_count           <= '0;
            operating_flag     <= 1'b0;
            Vmem_ram_address   <= '0;
            Weight_rom_address <= '0;
            Location_M         <= '0;
            Location_N         <= '0;
        end else begin
            step_done <= 1'b0;
            ev_drop   <= 1'b0;
            if (step_end) begin
                pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pending) begin
                        // Clearing here wins over a step_end in the same cycle:
                        // a repeated step_end never yields a second step_done.
                        step_done <= 1'b1;
                        pending   <= 1'b0;
                        ev_count  <= '0;
                    end else if (ev_valid) begin
                        if (ev_in_range) begin
                            state              <= SCAN;
                            m_q                <= ev_m;
                            n_q                <= ev_n;
                            i_q                <= '0;
                            j_q                <= '0;
                            operating_flag     <= flag_nxt;
                            Vmem_ram_address   <= addr_nxt;
                            Weight_rom_address <= wadr_nxt;
                            Location_M         <= loc_m_nxt;
                            Location_N         <= loc_n_nxt;
                        end else begin
                            ev_drop <= 1'b1;
                        end
                    end
                end

                SCAN: begin
                    if ((i_q == K_LAST) && (j_q == K_LAST)) begin
                        state          <= DRAIN;
                        drain_cnt      <= '0;
                        operating_flag <= 1'b0;
                        ev_count       <= ev_count + 16'd1;
                    end else begin
                        i_q                <= nxt_i;
                        j_q                <= nxt_j;
                        operating_flag     <= flag_nxt;
                        Vmem_ram_address   <= addr_nxt;
                        Weight_rom_address <= wadr_nxt;
                        Location_M         <= loc_m_nxt;
                        Location_N         <= loc_n_nxt;
                    end
                end

                DRAIN: begin
                    // Gap lets the core's read/add/write pipeline retire the last
                    // position before the next event can touch the same address.
                    if (drain_cnt == D_LAST) begin
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv1_event_scheduler.sv
// tb/tb_conv1_event_scheduler.sv - directed self-checking bench for conv1_event_scheduler
module tb_conv1_event_scheduler;

    localparam int KK = 25;
`ifdef CONV1_SCAN_PADSKIP_EN
    localparam int CORNER_FLAGS = 9;
`else
    localparam int CORNER_FLAGS = 25;
`endif

    logic        work_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ev_valid = 1'b0;
    logic        ev_ready;
    logic [7:0]  ev_m = '0;
    logic [7:0]  ev_n = '0;
    logic        step_end = 1'b0;
    logic        step_done;
    logic        ev_drop;
    logic        busy;
    logic [15:0] ev_count;
    logic        operating_flag;
    logic [15:0] Vmem_ram_address;
    logic [4:0]  Weight_rom_address;
    logic [7:0]  Location_M;
    logic [7:0]  Location_N;

    int errors = 0;
    int checks = 0;

    int f_lm, f_ln, f_w, f_v;
    int l_lm, l_ln, l_w, l_v;
    int n_flags, d_flags, d_ready;
    int n_acc, b_flags;
    int acc_at [3];
    int sd_cnt, sd_at, rdy_early, cnt_before, cnt_at_done;

    conv1_event_scheduler dut (
        .work_clk           (work_clk),
        .rst_n              (rst_n),
        .ev_valid           (ev_valid),
        .ev_ready           (ev_ready),
        .ev_m               (ev_m),
        .ev_n               (ev_n),
        .step_end           (step_end),
        .step_done          (step_done),
        .ev_drop            (ev_drop),
        .busy               (busy),
        .ev_count           (ev_count),
        .operating_flag     (operating_flag),
        .Vmem_ram_address   (Vmem_ram_address),
        .Weight_rom_address (Weight_rom_address),
        .Location_M         (Location_M),
        .Location_N         (Location_N)
    );

    always #5 work_clk = ~work_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge work_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one event and follow it through scan and drain; returns at accept + 29.
    task automatic do_event(input logic [7:0] m, input logic [7:0] n);
        ev_valid = 1'b1;
        ev_m = m;
        ev_n = n;
        tick();
        ev_valid = 1'b0;
        f_lm = int'(Location_M);
        f_ln = int'(Location_N);
        f_w = int'(Weight_rom_address);
        f_v = int'(Vmem_ram_address);
        n_flags = int'(operating_flag);
        for (int k = 1; k < KK; k++) begin
            tick();
            n_flags += int'(operating_flag);
        end
        l_lm = int'(Location_M);
        l_ln = int'(Location_N);
        l_w = int'(Weight_rom_address);
        l_v = int'(Vmem_ram_address);
        d_flags = 0;
        d_ready = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            d_flags += int'(operating_flag);
            d_ready += int'(ev_ready);
        end
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ev_ready", ev_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flag", operating_flag, 0);
        check("rst_ev_count", ev_count, 0);
        check("rst_vmem", Vmem_ram_address, 0);
        check("rst_step_done", step_done, 0);
        check("rst_ev_drop", ev_drop, 0);

        // Event (0,0)
        do_event(8'd0, 8'd0);
        check("e00_first_lm", f_lm, 0);
        check("e00_first_ln", f_ln, 0);
        check("e00_first_w", f_w, 24);
        check("e00_first_v", f_v, 0);
        check("e00_last_lm", l_lm, 4);
        check("e00_last_ln", l_ln, 4);
        check("e00_last_w", l_w, 0);
        check("e00_last_v", l_v, 132);
        check("e00_flags", n_flags, CORNER_FLAGS);
        check("e00_drain_flags", d_flags, 0);
        check("e00_drain_ready", d_ready, 0);
        check("e00_ready_t29", ev_ready, 1);
        check("e00_busy_t29", busy, 0);
        check("e00_ev_count", ev_count, 1);

        // Event (27,27): bottom-right corner
        do_event(8'd27, 8'd27);
        check("e27_first_v", f_v, 891);
        check("e27_first_w", f_w, 24);
        check("e27_last_lm", l_lm, 31);
        check("e27_last_ln", l_ln, 31);
        check("e27_last_v", l_v, 1023);
        check("e27_flags", n_flags, CORNER_FLAGS);
        check("e27_ev_count", ev_count, 2);

        // Back-to-back events with ev_valid held high
        ev_valid = 1'b1;
        ev_m = 8'd10;
        ev_n = 8'd10;
        n_acc = 0;
        b_flags = 0;
        acc_at[0] = 0;
        acc_at[1] = 0;
        acc_at[2] = 0;
        for (int c = 0; c <= 58; c++) begin
            if (ev_ready) begin
                if (n_acc < 3) acc_at[n_acc] = c;
                n_acc++;
            end
            if ((c >= 26 && c <= 28) || (c >= 55 && c <= 57)) b_flags += int'(operating_flag);
            tick();
        end
        ev_valid = 1'b0;
        for (int k = 0; k < 40 && !ev_ready; k++) tick();
        check("b2b_ready_after", ev_ready, 1);
        check("b2b_accepts", n_acc, 3);
        check("b2b_first_at", acc_at[0], 0);
        check("b2b_gap1", acc_at[1] - acc_at[0], 29);
        check("b2b_gap2", acc_at[2] - acc_at[1], 29);
        check("b2b_drain_flags", b_flags, 0);
        check("b2b_ev_count", ev_count, 5);

        // Out-of-range event (28,5)
        ev_valid = 1'b1;
        ev_m = 8'd28;
        ev_n = 8'd5;
        tick();
        ev_valid = 1'b0;
        check("drop_pulse", ev_drop, 1);
        check("drop_busy", busy, 0);
        check("drop_ready", ev_ready, 1);
        check("drop_ev_count", ev_count, 5);
        tick();
        check("drop_pulse_end", ev_drop, 0);
        check("drop_flag", operating_flag, 0);

        // step_end during SCAN, second step_end while pending
        ev_valid = 1'b1;
        ev_m = 8'd3;
        ev_n = 8'd4;
        tick();
        ev_valid = 1'b0;
        sd_cnt = 0;
        sd_at = 0;
        rdy_early = 0;
        cnt_before = -1;
        cnt_at_done = -1;
        for (int c = 1; c <= 40; c++) begin
            step_end = (c == 5 || c == 10);
            if (step_done) begin
                sd_cnt++;
                sd_at = c;
                cnt_at_done = int'(ev_count);
            end
            if (sd_at == 0 && ev_ready) rdy_early++;
            if (c == 29) cnt_before = int'(ev_count);
            tick();
        end
        step_end = 1'b0;
        check("se_done_count", sd_cnt, 1);
        check("se_done_at", sd_at, 30);
        check("se_ready_early", rdy_early, 0);
        check("se_count_before", cnt_before, 6);
        check("se_count_cleared", cnt_at_done, 0);

        // step_end coincident with an accept in IDLE
        sd_cnt = 0;
        sd_at = 0;
        cnt_before = -1;
        for (int c = 0; c <= 40; c++) begin
            ev_valid = (c == 0);
            step_end = (c == 0);
            ev_m = 8'd1;
            ev_n = 8'd1;
            if (step_done) begin
                sd_cnt++;
                sd_at = c;
            end
            if (c == 29) cnt_before = int'(ev_count);
            tick();
        end
        ev_valid = 1'b0;
        step_end = 1'b0;
        check("sim_done_count", sd_cnt, 1);
        check("sim_done_at", sd_at, 30);
        check("sim_count_before", cnt_before, 1);
        check("sim_count_after", ev_count, 0);

        // Reset in the middle of a scan
        ev_valid = 1'b1;
        ev_m = 8'd5;
        ev_n = 8'd5;
        tick();
        ev_valid = 1'b0;
        tick();
        tick();
        tick();
        check("mid_busy_pre", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_flag", operating_flag, 0);
        check("mid_rst_vmem", Vmem_ram_address, 0);
        check("mid_rst_loc_m", Location_M, 0);
        check("mid_rst_loc_n", Location_N, 0);
        check("mid_rst_ready", ev_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", ev_count, 0);
        tick();
        check("mid_rst_edge_busy", busy, 0);
        check("mid_rst_edge_flag", operating_flag, 0);
        rst_n = 1'b1;
        tick();
        check("post_rst_ready", ev_ready, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
